cla_seq_addsub: RTL and testbench

- Multi-cycle WIDTH-bit adder/subtractor built around one 4-bit carry-lookahead slice.
- Processes one nibble per clock, LSB first, and chains the carry through a register between nibbles.
- Adds valid/ready handshakes on both operand input and result output, so it drops into datapaths with backpressure.
- Complements the combinational 4-bit CLA: it is the wide, sequential, two-direction (add and subtract) consumer of that slice.

---
 rtl/cla_pkg.sv | 17 +
 rtl/cla.sv | 32 +++
 rtl/cla_seq_addsub.sv | 130 +++++++++++++
 tb/tb_cla_seq_addsub.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the sequential carry-lookahead adder/subtractor.
//   state_e     : controller states (IDLE, RUN, DONE)
//   SLICE_W     : width of the combinational lookahead slice
//   calc_nslice : number of slices needed for a given operand width
package cla_pkg;
  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int calc_nslice(input int width);
    return width / SLICE_W;
  endfunction
endpackage

// File: rtl/cla.sv
// 4-bit combinational carry-lookahead adder slice.
//   a, b  : nibble operands
//   c_in  : carry into bit 0
//   s     : nibble sum
//   c_out : carry out of bit 3
module cla (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       c_out
);
  logic [3:0] g, p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is a flat sum of products of g/p and c_in, so there is
  // no ripple path through the slice.
  assign c[0] = c_in;
  assign c[1] = g[0] | (p[0] & c_in);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c_in);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c_in);

  assign s     = p ^ c[3:0];
  assign c_out = c[4];
endmodule

// File: rtl/cla_seq_addsub.sv
// Multi-cycle WIDTH-bit adder/subtractor. One 4-bit lookahead slice is
// reused LSB nibble first, with the inter-nibble carry held in a register.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : operand handshake (a, b, sub)
//   sub                  : 0 = a+b, 1 = a-b
//   out_valid/out_ready  : result handshake (result, c_out, overflow)
//   c_out                : final carry; on subtract 1 means no borrow
//   overflow             : two's-complement signed overflow
// WIDTH must be a multiple of 4 and at least 4.
module cla_seq_addsub
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             overflow
);
  localparam int NSLICE = calc_nslice(WIDTH);
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_e             state_q, state_d;
  logic [KW-1:0]      k_q, k_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;        // b already conditionally inverted
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               c_out_q, c_out_d;
  logic               ovf_q, ovf_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic [SLICE_W-1:0] slc_a, slc_b, slc_s;
  logic               slc_co;

  assign slc_a = a_q[k_q*SLICE_W +: SLICE_W];
  assign slc_b = b_q[k_q*SLICE_W +: SLICE_W];

  cla u_slice (
    .a     (slc_a),
    .b     (slc_b),
    .c_in  (carry_q),
    .s     (slc_s),
    .c_out (slc_co)
  );

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    result_d = result_q;
    c_out_d  = c_out_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtract as a + ~b + 1: the +1 enters once, as nibble 0's carry.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        result_d[k_q*SLICE_W +: SLICE_W] = slc_s;
        carry_d = slc_co;
        if (k_q == KW'(NSLICE - 1)) begin
          c_out_d = slc_co;
          // Operand signs equal but sum sign differs; b_q is already the
          // effective operand, so this covers subtract too.
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                    (slc_s[SLICE_W-1] != a_q[WIDTH-1]);
          state_d = DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      c_out_q     <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      result_q    <= result_d;
      c_out_q     <= c_out_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign c_out     = c_out_q;
  assign overflow  = ovf_q;
endmodule

// File: tb/tb_cla_seq_addsub.sv
// Bench for cla_seq_addsub (WIDTH=16): directed operations checked every
// cycle against a transaction-level arithmetic model, with hand-computed
// literal expectations pinning the model on the directed cases.
module tb_cla_seq_addsub;
  localparam int WIDTH  = 16;
  localparam int NSLICE = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst, in_valid, in_ready, sub, out_valid, out_ready;
  logic             c_out, overflow;
  logic [WIDTH-1:0] a, b, result;

  always #5 clk = ~clk;

  cla_seq_addsub #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .c_out     (c_out),
    .overflow  (overflow)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference arithmetic on plain integers: {c_out, overflow, result}.
  function automatic logic [17:0] ref_op(input logic [15:0] x, input logic [15:0] y,
                                          input logic s);
    int ux, uy, sx, sy, full, sres;
    logic c, o;
    logic [15:0] r;
    ux = int'({16'd0, x});
    uy = int'({16'd0, y});
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (s) begin
      full = ux - uy;
      c    = (ux >= uy);
      sres = sx - sy;
    end else begin
      full = ux + uy;
      c    = (full > 65535);
      sres = sx + sy;
    end
    r = full[15:0];
    o = (sres > 32767) || (sres < -32768);
    return {c, o, r};
  endfunction

  // Transaction model: idle -> busy for NSLICE edges -> done until out_ready.
  localparam logic [1:0] M_IDLE = 2'd0, M_RUN = 2'd1, M_DONE = 2'd2;
  logic [1:0]  m_st = M_IDLE;
  int          m_cnt = 0;
  logic        m_fresh = 1'b0;
  logic        chk_en = 1'b0;
  logic [15:0] m_r = '0;
  logic        m_c = 1'b0, m_o = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_st    <= M_IDLE;
      m_fresh <= 1'b1;
      m_r     <= '0;
      m_c     <= 1'b0;
      m_o     <= 1'b0;
      chk_en  <= 1'b1;
    end else begin
      case (m_st)
        M_IDLE: if (in_valid) begin
          {m_c, m_o, m_r} <= ref_op(a, b, sub);
          m_cnt   <= 1;
          m_fresh <= 1'b0;
          m_st    <= M_RUN;
        end
        M_RUN: begin
          if (m_cnt == NSLICE) m_st <= M_DONE;
          else m_cnt <= m_cnt + 1;
        end
        default: if (out_ready) m_st <= M_IDLE;
      endcase
    end
  end

  // Literal expectations for the directed operation currently in flight.
  logic        lit_en = 1'b0;
  logic [15:0] lit_r = '0;
  logic        lit_c = 1'b0, lit_o = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 32'(in_ready), 32'(m_st == M_IDLE));
      chk("out_valid", 32'(out_valid), 32'(m_st == M_DONE));
      if (m_st == M_DONE || m_fresh) begin
        chk("result", 32'(result), 32'(m_r));
        chk("c_out", 32'(c_out), 32'(m_c));
        chk("overflow", 32'(overflow), 32'(m_o));
      end
      if (m_st == M_DONE && lit_en) begin
        chk("model_pin", 32'({m_c, m_o, m_r}), 32'({lit_c, lit_o, lit_r}));
        chk("lit_result", 32'(result), 32'(lit_r));
        chk("lit_flags", 32'({c_out, overflow}), 32'({lit_c, lit_o}));
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready) begin
      @(posedge clk); #1;
      n++;
      if (n > 50) begin
        $display("FAIL accept_timeout: in_ready never rose");
        $fatal(1);
      end
    end
  endtask

  // Issue one op and return #1 after the edge where out_valid first rises.
  task automatic start_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic ts,
                          input logic [15:0] er, input logic ec, input logic eo);
    int n = 0;
    lit_r = er; lit_c = ec; lit_o = eo; lit_en = 1'b1;
    a = ta; b = tb_v; sub = ts; in_valid = 1'b1;
    wait_ready();
    @(posedge clk); #1;
    // Operands are free to change once accepted.
    in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF; sub = ~ts;
    while (!out_valid) begin
      @(posedge clk); #1;
      n++;
      if (n > 50) begin
        $display("FAIL result_timeout: out_valid never rose");
        $fatal(1);
      end
    end
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    lit_en = 1'b0;
  endtask

  logic [15:0] bb_a [3] = '{16'h00FF, 16'h1000, 16'h8000};
  logic [15:0] bb_b [3] = '{16'h0F01, 16'h0001, 16'h8000};
  logic        bb_s [3] = '{1'b0, 1'b1, 1'b0};

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    start_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0); finish_op();
    start_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0); finish_op();
    start_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0); finish_op();
    start_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1); finish_op();

    // Backpressure: stall 5 cycles while offering new operands.
    start_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 1 || i == 2);
      a = 16'h0101; b = 16'h0202; sub = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    finish_op();
    @(posedge clk); #1;

    // Reset during the second RUN cycle abandons the operation.
    a = 16'hAAAA; b = 16'h5555; sub = 1'b0; in_valid = 1'b1;
    wait_ready();
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    start_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0); finish_op();

    // Back-to-back with both handshakes held high.
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = bb_a[i]; b = bb_b[i]; sub = bb_s[i];
      wait_ready();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (NSLICE + 4) @(posedge clk);
    #1 out_ready = 1'b0;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
